int_to_float_conv: RTL and testbench

Upstream feeder for the IIR filter stage. Converts a signed two's-complement fixed-point sample stream, such as ADC output, into IEEE-754 single-precision words. These words drive the filter's 32-bit i_signal input.
The conversion is a fixed 3-stage pipeline accepting one sample per clock. Output is held between valid samples, so the filter sees a stable value on every clock.

---
 rtl/float_pkg.sv | 16 +
 rtl/int_to_float_conv_if.sv | 26 ++
 rtl/lzc.sv | 21 ++
 rtl/int_to_float_conv.sv | 142 ++++++++++++++
 tb/tb_int_to_float_conv.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision definitions. Used by the int-to-float
// converter, the IIR stage and any downstream float-to-int block.
package float_pkg;

  localparam int          FP_BIAS   = 127;
  localparam int          FP_MANT_W = 23;
  localparam int          FP_EXP_W  = 8;
  localparam logic [31:0] FP_ZERO   = 32'h0;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } float_t;

endpackage

// File: rtl/int_to_float_conv_if.sv
// Sample-in / float-out stream bundle for the int-to-float converter.
// The master side feeds samples and receives floats; the converter is the slave.
interface int_to_float_conv_if #(
  parameter int IN_W = 16
) ();

  logic            i_valid;
  logic [IN_W-1:0] i_sample;
  logic            o_valid;
  logic [31:0]     o_signal;

  modport master (
    output i_valid,
    output i_sample,
    input  o_valid,
    input  o_signal
  );

  modport slave (
    input  i_valid,
    input  i_sample,
    output o_valid,
    output o_signal
  );

endinterface

// File: rtl/lzc.sv
// Combinational leading-zero counter. Returns W for an all-zero input so the
// caller can shift by the count without a special case.
module lzc #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count
);

  // Scan from LSB upward; the highest set bit is the last one to win.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) begin
        count = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/int_to_float_conv.sv
// Three-stage signed fixed-point (Q format) to IEEE-754 single converter.
// S1: sign / magnitude / zero flag. S2: normalize via leading-zero count.
// S3: round to nearest even, pack, and hold the result between samples.
// The interface instance width must equal IN_W.
module int_to_float_conv
  import float_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic               clk,
  input  logic               reset_l,
  int_to_float_conv_if.slave bus
);

  localparam int LZ_W  = $clog2(IN_W + 1);
  // Pads the normalized magnitude to 33 bits: leading one, 23 mantissa
  // bits, guard bit and 8 sticky bits, whatever IN_W is.
  localparam int PAD_W = 33 - IN_W;

  if (IN_W < 2 || IN_W > 32) begin : g_bad_in_w
    $error("int_to_float_conv: IN_W must lie in 2..32");
  end
  if (FRAC_BITS < 0 || FRAC_BITS > IN_W - 1) begin : g_bad_frac
    $error("int_to_float_conv: FRAC_BITS must lie in 0..IN_W-1");
  end

  // ---------------- S1 ----------------
  logic            s1_valid_reg;
  logic            s1_sign_reg;
  logic            s1_zero_reg;
  logic [IN_W-1:0] s1_mag_reg;
  logic [IN_W-1:0] mag_next;

  // The most negative input negates to 2^(IN_W-1), which still fits unsigned.
  assign mag_next = bus.i_sample[IN_W-1] ? ({IN_W{1'b0}} - bus.i_sample) : bus.i_sample;

  // S1 register: data only loads on valid so bubbles (and X) never enter.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_zero_reg  <= 1'b0;
      s1_mag_reg   <= '0;
    end else begin
      s1_valid_reg <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sign_reg <= bus.i_sample[IN_W-1];
        s1_zero_reg <= (bus.i_sample == '0);
        s1_mag_reg  <= mag_next;
      end
    end
  end

  // ---------------- S2 ----------------
  logic [LZ_W-1:0]   lz_count;
  logic signed [7:0] exp_next;
  logic              s2_valid_reg;
  logic              s2_sign_reg;
  logic              s2_zero_reg;
  logic signed [7:0] s2_exp_reg;
  logic [IN_W-1:0]   s2_norm_reg;

  lzc #(.W(IN_W)) u_lzc (
    .data  (s1_mag_reg),
    .count (lz_count)
  );

  // Unbiased exponent: msb position minus the binary-point offset.
  assign exp_next = 8'(IN_W - 1 - int'(lz_count) - FRAC_BITS);

  // S2 register: normalized magnitude with the leading one at bit IN_W-1.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_zero_reg  <= 1'b0;
      s2_exp_reg   <= '0;
      s2_norm_reg  <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sign_reg <= s1_sign_reg;
        s2_zero_reg <= s1_zero_reg;
        s2_exp_reg  <= exp_next;
        s2_norm_reg <= s1_mag_reg << lz_count;
      end
    end
  end

  // ---------------- S3 ----------------
  logic [32:0] ext;
  logic        lead;
  logic [22:0] mant_trunc;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_sum;
  logic        carry;
  logic [7:0]  exp_biased;
  float_t      result;
  logic        o_valid_reg;
  float_t      o_signal_reg;

  // Round-to-nearest-even and packing; narrow inputs get zero guard/sticky.
  always_comb begin
    ext        = {s2_norm_reg, {PAD_W{1'b0}}};
    lead       = ext[32];
    mant_trunc = ext[31:9];
    guard      = ext[8];
    sticky     = |ext[7:0];
    round_up   = guard & (sticky | mant_trunc[0]);
    mant_sum   = {1'b0, mant_trunc} + {23'd0, round_up};
    // A carry out leaves the low 23 bits all zero, which is the cleared mantissa.
    carry      = mant_sum[23];
    exp_biased = 8'(int'(s2_exp_reg) + FP_BIAS + int'(carry));
    result     = FP_ZERO;
    // Zero flag and missing leading one both mean zero; either forces +0.0.
    if (!s2_zero_reg && lead) begin
      result.sign = s2_sign_reg;
      result.exp  = exp_biased;
      result.mant = mant_sum[22:0];
    end
  end

  // Output register: updates only when a valid sample leaves S2.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      o_valid_reg  <= 1'b0;
      o_signal_reg <= FP_ZERO;
    end else begin
      o_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        o_signal_reg <= result;
      end
    end
  end

  assign bus.o_valid  = o_valid_reg;
  assign bus.o_signal = o_signal_reg;

endmodule

// File: tb/tb_int_to_float_conv.sv
// Self-checking bench for int_to_float_conv: three instances cover the
// Q0 16-bit, Q15 16-bit and Q0 32-bit configurations.
module tb_int_to_float_conv;

  logic clk;
  logic reset_l;
  int   total;
  int   bad;
  logic [31:0] held16, heldq, held32;

  int_to_float_conv_if #(.IN_W(16)) bus16 ();
  int_to_float_conv_if #(.IN_W(16)) busq ();
  int_to_float_conv_if #(.IN_W(32)) bus32 ();

  int_to_float_conv #(.IN_W(16), .FRAC_BITS(0))  u_d16 (.clk(clk), .reset_l(reset_l), .bus(bus16));
  int_to_float_conv #(.IN_W(16), .FRAC_BITS(15)) u_q15 (.clk(clk), .reset_l(reset_l), .bus(busq));
  int_to_float_conv #(.IN_W(32), .FRAC_BITS(0))  u_d32 (.clk(clk), .reset_l(reset_l), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value = val / 2^frac, rounded to single precision with plain
  // integer arithmetic (quotient/remainder against the halfway point).
  function automatic logic [31:0] ref_float(input longint val, input int frac);
    logic [63:0] m, q, rem, half;
    int p, sh;
    logic [7:0] e;
    if (val == 0) return 32'h0;
    m = (val < 0) ? 64'(-val) : 64'(val);
    p = 63;
    while (p > 0 && !m[p]) p--;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    e = 8'(p - frac + 127);
    return {(val < 0), e, q[22:0]};
  endfunction

  task automatic idle_all();
    bus16.i_valid = 1'b0; bus16.i_sample = '0;
    busq.i_valid  = 1'b0; busq.i_sample  = '0;
    bus32.i_valid = 1'b0; bus32.i_sample = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_l = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    held16 = 32'h0; heldq = 32'h0; held32 = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_l = 1'b0;
    idle_all();
    #1;
    total++; if (bus16.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid16: got %b want 0", bus16.o_valid); end
    total++; if (bus16.o_signal !== 32'h0) begin bad++; $display("FAIL reset_sig16: got %h want 00000000", bus16.o_signal); end
    total++; if (busq.o_valid !== 1'b0) begin bad++; $display("FAIL reset_validq: got %b want 0", busq.o_valid); end
    total++; if (busq.o_signal !== 32'h0) begin bad++; $display("FAIL reset_sigq: got %h want 00000000", busq.o_signal); end
    total++; if (bus32.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid32: got %b want 0", bus32.o_valid); end
    total++; if (bus32.o_signal !== 32'h0) begin bad++; $display("FAIL reset_sig32: got %h want 00000000", bus32.o_signal); end
    @(negedge clk);
    reset_l = 1'b1;
    held16 = 32'h0; heldq = 32'h0; held32 = 32'h0;
  endtask

  task automatic test_single();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus16.i_valid  = (c == 0);
      bus16.i_sample = (c == 0) ? 16'd500 : 16'd0;
      @(posedge clk); #1;
      if (c == 2) held16 = 32'h43FA0000;
      total++; if (bus16.o_valid !== (c == 2)) begin bad++; $display("FAIL single_valid c=%0d: got %b want %b", c, bus16.o_valid, (c == 2)); end
      total++; if (bus16.o_signal !== held16) begin bad++; $display("FAIL single_sig c=%0d: got %h want %h", c, bus16.o_signal, held16); end
    end
  endtask

  task automatic test_stream();
    int          vals [5] = '{31, 63, -31, -63, 0};
    logic [31:0] want [5] = '{32'h41F80000, 32'h427C0000, 32'hC1F80000, 32'hC27C0000, 32'h00000000};
    int k;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus16.i_valid  = (c < 5);
      bus16.i_sample = (c < 5) ? 16'(vals[c]) : 16'd0;
      @(posedge clk); #1;
      k = c - 2;
      if (k >= 0 && k < 5) held16 = want[k];
      total++; if (bus16.o_valid !== (k >= 0 && k < 5)) begin bad++; $display("FAIL stream_valid c=%0d: got %b want %b", c, bus16.o_valid, (k >= 0 && k < 5)); end
      total++; if (bus16.o_signal !== held16) begin bad++; $display("FAIL stream_sig c=%0d: got %h want %h", c, bus16.o_signal, held16); end
    end
  endtask

  task automatic test_corners();
    logic [15:0] in16 [2] = '{16'h8000, 16'hFFFF};
    logic [15:0] inq  [2] = '{16'h8000, 16'h4000};
    logic [31:0] w16  [2] = '{32'hC7000000, 32'hBF800000};
    logic [31:0] wq   [2] = '{32'hBF800000, 32'h3F000000};
    int k;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus16.i_valid = (c < 2); bus16.i_sample = (c < 2) ? in16[c] : 16'd0;
      busq.i_valid  = (c < 2); busq.i_sample  = (c < 2) ? inq[c]  : 16'd0;
      @(posedge clk); #1;
      k = c - 2;
      if (k >= 0 && k < 2) begin held16 = w16[k]; heldq = wq[k]; end
      total++; if (bus16.o_signal !== held16) begin bad++; $display("FAIL corner_sig16 c=%0d: got %h want %h", c, bus16.o_signal, held16); end
      total++; if (busq.o_signal !== heldq) begin bad++; $display("FAIL corner_sigq15 c=%0d: got %h want %h", c, busq.o_signal, heldq); end
      total++; if (busq.o_valid !== (k >= 0 && k < 2)) begin bad++; $display("FAIL corner_validq15 c=%0d: got %b want %b", c, busq.o_valid, (k >= 0 && k < 2)); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] ins  [4] = '{32'h01000001, 32'h01000003, 32'h01FFFFFF, 32'h80000000};
    logic [31:0] want [4] = '{32'h4B800000, 32'h4B800002, 32'h4C000000, 32'hCF000000};
    int k;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus32.i_valid  = (c < 4);
      bus32.i_sample = (c < 4) ? ins[c] : 32'd0;
      @(posedge clk); #1;
      k = c - 2;
      if (k >= 0 && k < 4) held32 = want[k];
      total++; if (bus32.o_valid !== (k >= 0 && k < 4)) begin bad++; $display("FAIL round_valid c=%0d: got %b want %b", c, bus32.o_valid, (k >= 0 && k < 4)); end
      total++; if (bus32.o_signal !== held32) begin bad++; $display("FAIL round_sig c=%0d: got %h want %h", c, bus32.o_signal, held32); end
    end
  endtask

  task automatic test_bubbles();
    logic        ev [14];
    logic [31:0] es [14];
    logic [15:0] s;
    int k;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      ev[c] = (c < 12) && (c % 2 == 0);
      if (ev[c]) begin
        s = 16'($urandom);
        bus16.i_valid = 1'b1; bus16.i_sample = s;
        es[c] = ref_float(longint'($signed(s)), 0);
      end else begin
        bus16.i_valid = 1'b0; bus16.i_sample = 'x;
        es[c] = 32'h0;
      end
      @(posedge clk); #1;
      k = c - 2;
      if (k >= 0 && ev[k]) held16 = es[k];
      total++; if ($isunknown(bus16.o_signal)) begin bad++; $display("FAIL bubble_x c=%0d: got %h want known", c, bus16.o_signal); end
      total++; if (bus16.o_valid !== (k >= 0 && ev[k])) begin bad++; $display("FAIL bubble_valid c=%0d: got %b want %b", c, bus16.o_valid, (k >= 0 && ev[k])); end
      total++; if (bus16.o_signal !== held16) begin bad++; $display("FAIL bubble_sig c=%0d: got %h want %h", c, bus16.o_signal, held16); end
    end
    bus16.i_sample = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); bus16.i_valid = 1'b1; bus16.i_sample = 16'd1000;
    @(negedge clk); bus16.i_valid = 1'b1; bus16.i_sample = 16'd2000;
    @(posedge clk); #2;
    reset_l = 1'b0;
    #1;
    total++; if (bus16.o_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", bus16.o_valid); end
    total++; if (bus16.o_signal !== 32'h0) begin bad++; $display("FAIL midreset_sig: got %h want 00000000", bus16.o_signal); end
    @(negedge clk); bus16.i_valid = 1'b1; bus16.i_sample = 16'd3000;
    @(negedge clk); idle_all();
    @(negedge clk); reset_l = 1'b1;
    held16 = 32'h0; heldq = 32'h0; held32 = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++; if (bus16.o_valid !== 1'b0) begin bad++; $display("FAIL postreset_valid c=%0d: got %b want 0", c, bus16.o_valid); end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus16.i_valid  = (c == 0);
      bus16.i_sample = (c == 0) ? 16'd500 : 16'd0;
      @(posedge clk); #1;
      if (c == 2) held16 = 32'h43FA0000;
      total++; if (bus16.o_valid !== (c == 2)) begin bad++; $display("FAIL restart_valid c=%0d: got %b want %b", c, bus16.o_valid, (c == 2)); end
      total++; if (bus16.o_signal !== held16) begin bad++; $display("FAIL restart_sig c=%0d: got %h want %h", c, bus16.o_signal, held16); end
    end
  endtask

  localparam int RN = 300;

  task automatic test_random();
    logic        v16 [RN], vq [RN], v32 [RN];
    logic [31:0] e16 [RN], eq [RN], e32 [RN];
    logic [15:0] s16, sq;
    logic [31:0] s32;
    int k;
    do_reset();
    for (int c = 0; c < RN + 3; c++) begin
      @(negedge clk);
      if (c < RN) begin
        s16 = 16'($urandom >> $urandom_range(0, 16));
        if ($urandom_range(0, 1) == 1) s16 = -s16;
        if ($urandom_range(0, 19) == 0) s16 = 16'h8000;
        sq  = 16'($urandom >> $urandom_range(0, 16));
        s32 = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) s32 = -s32;
        if ($urandom_range(0, 29) == 0) s32 = 32'h80000000;
        v16[c] = ($urandom_range(0, 3) != 0);
        vq[c]  = ($urandom_range(0, 3) != 0);
        v32[c] = ($urandom_range(0, 3) != 0);
        e16[c] = ref_float(longint'($signed(s16)), 0);
        eq[c]  = ref_float(longint'($signed(sq)), 15);
        e32[c] = ref_float(longint'($signed(s32)), 0);
        bus16.i_valid = v16[c]; bus16.i_sample = s16;
        busq.i_valid  = vq[c];  busq.i_sample  = sq;
        bus32.i_valid = v32[c]; bus32.i_sample = s32;
      end else begin
        idle_all();
      end
      @(posedge clk); #1;
      k = c - 2;
      if (k >= 0 && k < RN) begin
        if (v16[k]) held16 = e16[k];
        if (vq[k])  heldq  = eq[k];
        if (v32[k]) held32 = e32[k];
        total++; if (bus16.o_valid !== v16[k]) begin bad++; $display("FAIL rand_valid16 c=%0d: got %b want %b", c, bus16.o_valid, v16[k]); end
        total++; if (busq.o_valid !== vq[k]) begin bad++; $display("FAIL rand_validq15 c=%0d: got %b want %b", c, busq.o_valid, vq[k]); end
        total++; if (bus32.o_valid !== v32[k]) begin bad++; $display("FAIL rand_valid32 c=%0d: got %b want %b", c, bus32.o_valid, v32[k]); end
      end
      total++; if (bus16.o_signal !== held16) begin bad++; $display("FAIL rand_sig16 c=%0d: got %h want %h", c, bus16.o_signal, held16); end
      total++; if (busq.o_signal !== heldq) begin bad++; $display("FAIL rand_sigq15 c=%0d: got %h want %h", c, busq.o_signal, heldq); end
      total++; if (bus32.o_signal !== held32) begin bad++; $display("FAIL rand_sig32 c=%0d: got %h want %h", c, bus32.o_signal, held32); end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    held16  = 32'h0;
    heldq   = 32'h0;
    held32  = 32'h0;
    reset_l = 1'b1;
    idle_all();
    test_reset();
    test_single();
    test_stream();
    test_corners();
    test_rounding();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
